// File: rtl/pwm_peripheral.sv
// 16-pin PWM output stage driven by the SPI configuration registers.
// Duty and PWM-enable are shadowed at period wrap; output-enable acts immediately.
module pwm_peripheral #(
    parameter int CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0] CNT_LAST = 8'd254;

    logic [DIV_W-1:0] div_cnt;
    logic [7:0]       pwm_cnt;
    logic [7:0]       duty_sh;
    logic [15:0]      pwm_en_sh;
    logic [15:0]      en_out;
    logic [15:0]      pin_mask;
    logic             tick;
    logic             wrap;
    logic             pwm_lvl;

    assign en_out  = {en_reg_out_15_8, en_reg_out_7_0};
    assign tick    = (div_cnt == DIV_LAST);
    assign wrap    = tick && (pwm_cnt == CNT_LAST);
    assign pwm_lvl = (pwm_cnt < duty_sh);

    // Non-PWM pins sit static high; PWM pins follow the shared level.
    assign pin_mask = ~pwm_en_sh | {16{pwm_lvl}};

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt      <= '0;
            pwm_cnt      <= '0;
            duty_sh      <= '0;
            pwm_en_sh    <= '0;
            period_start <= 1'b0;
            out          <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                pwm_cnt <= wrap ? 8'd0 : pwm_cnt + 8'd1;
            end
            if (wrap) begin
                duty_sh   <= pwm_duty_cycle;
                pwm_en_sh <= {en_reg_pwm_15_8, en_reg_pwm_7_0};
            end
            period_start <= wrap;
            out          <= en_out & pin_mask;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Randomized and directed bench for pwm_peripheral, two instances (CLK_DIV=2 and 1)
// checked every cycle against a cycle-count based model of the PWM timing.
module tb_pwm_peripheral;

    logic        clk;
    logic        rst;
    logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
    logic [15:0] out_a, out_b;
    logic        ps_a, ps_b;

    int compared   = 0;
    int mismatched = 0;

    pwm_peripheral #(.CLK_DIV(2)) dut_a (
        .clk(clk), .rst(rst),
        .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
        .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
        .pwm_duty_cycle(duty),
        .out(out_a), .period_start(ps_a)
    );

    pwm_peripheral #(.CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst),
        .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
        .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
        .pwm_duty_cycle(duty),
        .out(out_b), .period_start(ps_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state is derived from the number of clocks since reset released:
    // step = n / div, count = step mod 255, a period is 255*div clocks.
    function automatic logic modelLevel(int n, int div, logic [7:0] d);
        int c;
        c = (n / div) % 255;
        return (c < int'(d));
    endfunction

    function automatic logic modelWrap(int n, int div);
        return (n % (255 * div)) == (255 * div - 1);
    endfunction

    int          n_a, n_b;
    logic [7:0]  dsh_a, dsh_b;
    logic [15:0] psh_a, psh_b;
    logic [15:0] exp_out_a, exp_out_b;
    logic        exp_ps_a, exp_ps_b;
    logic        model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            n_a <= 0; n_b <= 0;
            dsh_a <= '0; dsh_b <= '0;
            psh_a <= '0; psh_b <= '0;
            exp_out_a <= '0; exp_out_b <= '0;
            exp_ps_a <= 1'b0; exp_ps_b <= 1'b0;
            model_valid <= 1'b1;
        end else begin
            exp_out_a <= {eo_hi, eo_lo} & (~psh_a | {16{modelLevel(n_a, 2, dsh_a)}});
            exp_out_b <= {eo_hi, eo_lo} & (~psh_b | {16{modelLevel(n_b, 1, dsh_b)}});
            exp_ps_a  <= modelWrap(n_a, 2);
            exp_ps_b  <= modelWrap(n_b, 1);
            if (modelWrap(n_a, 2)) begin
                dsh_a <= duty;
                psh_a <= {ep_hi, ep_lo};
            end
            if (modelWrap(n_b, 1)) begin
                dsh_b <= duty;
                psh_b <= {ep_hi, ep_lo};
            end
            n_a <= n_a + 1;
            n_b <= n_b + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("out_a", 32'(out_a), 32'(exp_out_a));
            checkOutput("period_start_a", 32'(ps_a), 32'(exp_ps_a));
            checkOutput("out_b", 32'(out_b), 32'(exp_out_b));
            checkOutput("period_start_b", 32'(ps_b), 32'(exp_ps_b));
        end
    end

    task automatic applyStimulus(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        {eo_hi, eo_lo} = eo;
        {ep_hi, ep_lo} = ep;
        duty = d;
    endtask

    // Waits for period_start on instance a (sel=0) or b (sel=1); returns cycles waited.
    task automatic waitPs(input bit sel, output int cyc);
        cyc = 0;
        while (cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if ((sel ? ps_b : ps_a) === 1'b1) return;
        end
        checkOutput("period_start_timeout", 32'(0), 32'(1));
    endtask

    task automatic countHigh(input int ncyc, output int hi);
        hi = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (out_a[0] === 1'b1) hi++;
        end
    endtask

    int cyc, h1, h2, h3, changes;
    logic [15:0] prev;

    initial begin
        rst = 1'b1;
        applyStimulus(16'h0000, 16'h0000, 8'h00);
        repeat (3) @(negedge clk);
        checkOutput("reset_out", 32'(out_a), 32'h0);
        rst = 1'b0;

        // Static-high pins: immediate and stable over two periods.
        applyStimulus(16'hFFFF, 16'h0000, 8'h00);
        @(negedge clk);
        checkOutput("static_high", 32'(out_a), 32'hFFFF);
        changes = 0;
        prev = out_a;
        repeat (1020) begin
            @(negedge clk);
            if (out_a !== prev) changes++;
            prev = out_a;
        end
        checkOutput("static_no_toggle", 32'(changes), 32'd0);

        // Duty 0x80: 128 steps * 2 clocks high per 510-clock period.
        applyStimulus(16'h0001, 16'h0001, 8'h80);
        waitPs(1'b0, cyc);
        countHigh(510, h1);
        checkOutput("duty80_high", 32'(h1), 32'd256);
        checkOutput("duty80_ps_at_end", 32'(ps_a), 32'd1);

        // Duty boundaries: 0 never high, 0xFF always high.
        applyStimulus(16'h0001, 16'h0001, 8'h00);
        waitPs(1'b0, cyc);
        applyStimulus(16'h0001, 16'h0001, 8'hFF);
        countHigh(510, h1);
        checkOutput("duty00_high", 32'(h1), 32'd0);
        countHigh(510, h2);
        checkOutput("dutyFF_high", 32'(h2), 32'd510);

        // Mid-period duty change waits for the next period.
        applyStimulus(16'h0001, 16'h0001, 8'h40);
        waitPs(1'b0, cyc);
        countHigh(255, h1);
        applyStimulus(16'h0001, 16'h0001, 8'hC0);
        countHigh(255, h2);
        checkOutput("shadow_old_period", 32'(h1 + h2), 32'd128);
        checkOutput("shadow_boundary_ps", 32'(ps_a), 32'd1);
        countHigh(510, h3);
        checkOutput("shadow_new_period", 32'(h3), 32'd384);

        // Reset mid-activity, then first period_start after 510 clocks.
        applyStimulus(16'hFFFF, 16'hFFFF, 8'h80);
        repeat (37) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("midreset_out_a", 32'(out_a), 32'h0);
        checkOutput("midreset_ps_a", 32'(ps_a), 32'h0);
        checkOutput("midreset_out_b", 32'(out_b), 32'h0);
        rst = 1'b0;
        waitPs(1'b0, cyc);
        checkOutput("first_ps_delay", 32'(cyc), 32'd510);

        // CLK_DIV=1: gating a pin mid-high-phase acts next cycle, period unchanged.
        applyStimulus(16'h0001, 16'h0001, 8'h80);
        waitPs(1'b1, cyc);
        waitPs(1'b1, cyc);
        checkOutput("div1_period", 32'(cyc), 32'd255);
        cyc = 0;
        repeat (10) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("div1_high_before_gate", 32'(out_b[0]), 32'd1);
        applyStimulus(16'h0000, 16'h0001, 8'h80);
        @(negedge clk);
        cyc++;
        checkOutput("div1_gate_next_cycle", 32'(out_b[0]), 32'd0);
        while (ps_b !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("div1_period_after_gate", 32'(cyc), 32'd255);

        // Randomized traffic with occasional resets; the compare process checks each cycle.
        repeat (6000) begin
            @(negedge clk);
            if (rst) begin
                rst = ($urandom_range(0, 2) == 0);
            end else if ($urandom_range(0, 999) == 0) begin
                rst = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: duty = 8'h00;
                    1: duty = 8'hFF;
                    default: duty = 8'($urandom);
                endcase
                {eo_hi, eo_lo} = 16'($urandom);
                {ep_hi, ep_lo} = 16'($urandom);
            end
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
